// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states, access sizes
// and the legality/alignment helpers used at request accept time.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_RESP = 2'b11
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } lsu_size_e;

    // funct3[1:0] carries the size for both loads and stores; 11 is never legal.
    function automatic lsu_size_e f3_size(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic misaligned(input lsu_size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_HALF: return lo[0];
            SZ_WORD: return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the data port: byte enables and replicated store data on the
// way out, lane extraction plus sign/zero extension of load data on the way back.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                be_o    = 4'b0011 << addr_lo_i;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
    end

    assign byte_sel = mem_rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = mem_rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        rdata_o = 32'h0000_0000;
        case (funct3_i)
            F3_LB:   rdata_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   rdata_o = {{16{half_sel[15]}}, half_sel};
            F3_LW:   rdata_o = mem_rdata_i;
            F3_LBU:  rdata_o = {24'h000000, byte_sel};
            F3_LHU:  rdata_o = {16'h0000, half_sel};
            default: rdata_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request/grant/response transaction per op on the data port,
// with registered memory-side outputs and a registered, extended load result.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [2:0]            funct3,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  req_ready,
    output logic                  stall,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  fault,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    lsu_state_e           state_q;
    logic [1:0]           addr_lo_q;
    logic [2:0]           funct3_q;
    logic                 write_q;
    logic                 resp_valid_q;
    logic                 fault_q;
    logic [DATA_W-1:0]    rdata_q;
    logic                 mem_req_q;
    logic                 mem_we_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [DATA_W/8-1:0]  mem_be_q;
    logic [DATA_W-1:0]    mem_wdata_q;

    logic                 is_idle;
    logic [1:0]           al_addr_lo;
    logic [2:0]           al_funct3;
    logic [3:0]           al_be;
    logic [31:0]          al_wdata;
    logic [31:0]          al_rdata;
    logic                 op_ok;

    assign is_idle = (state_q == ST_IDLE);

    // Live inputs drive the aligner at accept; the captured op drives it afterwards
    // so load extraction in WAIT sees the original lane and funct3.
    assign al_addr_lo = is_idle ? addr[1:0] : addr_lo_q;
    assign al_funct3  = is_idle ? funct3 : funct3_q;

    assign op_ok = f3_legal(req_write, funct3) &&
                   !misaligned(f3_size(funct3[1:0]), addr[1:0]);

    lsu_align u_align (
        .size_i      (f3_size(al_funct3[1:0])),
        .addr_lo_i   (al_addr_lo),
        .funct3_i    (al_funct3),
        .wdata_i     (wdata),
        .mem_rdata_i (mem_rdata),
        .be_o        (al_be),
        .wdata_o     (al_wdata),
        .rdata_o     (al_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_lo_q    <= 2'b00;
            funct3_q     <= 3'b000;
            write_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            rdata_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    resp_valid_q <= 1'b0;
                    if (req_valid) begin
                        addr_lo_q <= addr[1:0];
                        funct3_q  <= funct3;
                        write_q   <= req_write;
                        if (op_ok) begin
                            state_q     <= ST_REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_write;
                            mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                            mem_be_q    <= al_be;
                            mem_wdata_q <= req_write ? al_wdata : '0;
                        end else begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            fault_q      <= 1'b1;
                            rdata_q      <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_be_q    <= '0;
                        mem_wdata_q <= '0;
                        if (write_q) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            fault_q      <= 1'b0;
                            rdata_q      <= '0;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        fault_q      <= 1'b0;
                        rdata_q      <= al_rdata;
                    end
                end
                ST_RESP: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = is_idle;
    assign stall      = !is_idle;
    assign resp_valid = resp_valid_q;
    assign fault      = fault_q;
    assign rdata      = rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the load/store unit: scripted memory responder with
// configurable grant/rvalid delays and hand-computed expected results.
module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        req_ready;
    logic        stall;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .req_ready  (req_ready),
        .stall      (stall),
        .resp_valid (resp_valid),
        .rdata      (rdata),
        .fault      (fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Results of the most recent run_op
    int          o_lat;
    int          o_nresp;
    logic        o_saw_req;
    logic        o_stable;
    logic        o_stall_ok;
    logic [31:0] o_rdata;
    logic        o_fault;
    logic [31:0] o_addr;
    logic [3:0]  o_be;
    logic [31:0] o_wdata;
    logic        o_we;
    logic [3:0]  o_be_after;
    logic        o_ready_after;
    logic [31:0] o_hold;

    // Presents one op (cycle 0), grants after gnt_dly REQ cycles and returns
    // rvalid rv_dly cycles into WAIT; o_lat is the resp_valid cycle number.
    task automatic run_op(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int gnt_dly, input int rv_dly);
        int   req_n;
        int   wait_n;
        logic granted;
        logic rv_done;
        req_n = 0; wait_n = 0; granted = 1'b0; rv_done = 1'b0;
        o_lat = 0; o_nresp = 0; o_saw_req = 1'b0; o_stable = 1'b1; o_stall_ok = 1'b1;
        o_rdata = 32'hBAD0_BAD0; o_fault = 1'b0; o_addr = '0; o_be = '0; o_wdata = '0;
        o_we = 1'b0; o_be_after = 4'hF; o_ready_after = 1'b0; o_hold = 32'hBAD0_BAD0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; funct3 = f3; addr = a; wdata = wd;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            req_valid  = 1'b0;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h5A5A_5A5A;
            if (granted && !wr && !rv_done) begin
                if (wait_n == rv_dly) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rd;
                    rv_done    = 1'b1;
                end
                wait_n++;
            end
            if (mem_req === 1'b1) begin
                if (!o_saw_req) begin
                    o_saw_req = 1'b1;
                    o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata; o_we = mem_we;
                end else if (mem_addr !== o_addr || mem_be !== o_be ||
                             mem_wdata !== o_wdata || mem_we !== o_we) begin
                    o_stable = 1'b0;
                end
                if (req_n == gnt_dly) begin
                    mem_gnt = 1'b1;
                    granted = 1'b1;
                end
                req_n++;
            end
            if (resp_valid === 1'b1) begin
                o_nresp++;
                if (o_lat == 0) begin
                    o_lat = k; o_rdata = rdata; o_fault = fault;
                end
            end
            if ((o_lat == 0 || o_lat == k) && stall !== 1'b1) o_stall_ok = 1'b0;
            if (o_lat != 0 && k == o_lat + 1) begin
                o_be_after = mem_be; o_ready_after = req_ready;
            end
            if (o_lat != 0 && k == o_lat + 2) o_hold = rdata;
            if (o_lat != 0 && k == o_lat + 3) break;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    int n_spur;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; funct3 = 3'b000;
        addr = '0; wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_ctl", {26'd0, resp_valid, fault, mem_req, mem_we, 2'b00}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        chk("rst_mbe_wd", mem_wdata | {28'd0, mem_be}, 32'd0);
        rst_n = 1'b1;

        // SW aligned, immediate grant
        run_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
        chk("sw_addr", o_addr, 32'h100);
        chk("sw_be", {28'd0, o_be}, 32'hF);
        chk("sw_wdata", o_wdata, 32'hDEADBEEF);
        chk("sw_we", {31'd0, o_we}, 32'd1);
        chk("sw_lat", o_lat, 32'd2);
        chk("sw_fault", {31'd0, o_fault}, 32'd0);
        chk("sw_nresp", o_nresp, 32'd1);
        chk("sw_be_idle", {28'd0, o_be_after}, 32'd0);
        chk("sw_ready", {31'd0, o_ready_after}, 32'd1);

        // LB / LBU top lane
        run_op(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF7F01, 0, 0);
        chk("lb_be", {28'd0, o_be}, 32'h8);
        chk("lb_addr", o_addr, 32'h200);
        chk("lb_we", {31'd0, o_we}, 32'd0);
        chk("lb_rdata", o_rdata, 32'hFFFFFF80);
        chk("lb_lat", o_lat, 32'd3);
        chk("lb_hold", o_hold, 32'hFFFFFF80);
        run_op(1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF7F01, 0, 0);
        chk("lbu_rdata", o_rdata, 32'h00000080);

        // SH upper half, then LH same address
        run_op(1'b1, 3'b001, 32'h302, 32'h1234ABCD, 32'h0, 0, 0);
        chk("sh_be", {28'd0, o_be}, 32'hC);
        chk("sh_wdata", o_wdata, 32'hABCDABCD);
        chk("sh_addr", o_addr, 32'h300);
        chk("sh_rdata0", o_rdata, 32'd0);
        run_op(1'b0, 3'b001, 32'h302, 32'h0, 32'hABCD0000, 0, 0);
        chk("lh_be", {28'd0, o_be}, 32'hC);
        chk("lh_rdata", o_rdata, 32'hFFFFABCD);

        // Other lanes and extensions
        run_op(1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 0, 0);
        chk("sb_be", {28'd0, o_be}, 32'h2);
        chk("sb_wdata", o_wdata, 32'hA5A5A5A5);
        run_op(1'b0, 3'b101, 32'h200, 32'h0, 32'h1234F00D, 0, 0);
        chk("lhu_be", {28'd0, o_be}, 32'h3);
        chk("lhu_rdata", o_rdata, 32'h0000F00D);
        run_op(1'b0, 3'b000, 32'h201, 32'h0, 32'h80FF7F01, 0, 0);
        chk("lb1_rdata", o_rdata, 32'h0000007F);

        // Faults: misaligned word, illegal funct3 load/store, misaligned half
        run_op(1'b0, 3'b010, 32'h401, 32'h0, 32'h0, 0, 0);
        chk("lw_mis_req", {31'd0, o_saw_req}, 32'd0);
        chk("lw_mis_lat", o_lat, 32'd1);
        chk("lw_mis_fault", {31'd0, o_fault}, 32'd1);
        chk("lw_mis_rdata", o_rdata, 32'd0);
        run_op(1'b0, 3'b011, 32'h400, 32'h0, 32'h0, 0, 0);
        chk("ld011_fault", {31'd0, o_fault}, 32'd1);
        chk("ld011_req", {31'd0, o_saw_req}, 32'd0);
        run_op(1'b1, 3'b100, 32'h400, 32'h0, 32'h0, 0, 0);
        chk("st100_fault", {31'd0, o_fault}, 32'd1);
        run_op(1'b1, 3'b001, 32'h301, 32'h0, 32'h0, 0, 0);
        chk("sh_mis_fault", {31'd0, o_fault}, 32'd1);

        // LW with grant 3 cycles late and rvalid 2 more cycles into WAIT
        run_op(1'b0, 3'b010, 32'h500, 32'h0, 32'hCAFEF00D, 3, 2);
        chk("lw_slow_stable", {31'd0, o_stable}, 32'd1);
        chk("lw_slow_be", {28'd0, o_be}, 32'hF);
        chk("lw_slow_stall", {31'd0, o_stall_ok}, 32'd1);
        chk("lw_slow_nresp", o_nresp, 32'd1);
        chk("lw_slow_lat", o_lat, 32'd8);
        chk("lw_slow_rdata", o_rdata, 32'hCAFEF00D);
        chk("lw_slow_fault", {31'd0, o_fault}, 32'd0);

        // Reset while waiting for load data
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h600;
        @(negedge clk);
        req_valid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("rw_wait_req", {31'd0, mem_req}, 32'd0);
        chk("rw_wait_stall", {31'd0, stall}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_rst_req", {31'd0, mem_req}, 32'd0);
        chk("rw_rst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
        n_spur = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (resp_valid === 1'b1) n_spur++;
        end
        chk("rw_no_resp", n_spur, 32'd0);
        run_op(1'b1, 3'b010, 32'h700, 32'h01020304, 32'h0, 0, 0);
        chk("rw_sw_lat", o_lat, 32'd2);
        chk("rw_sw_wdata", o_wdata, 32'h01020304);
        chk("rw_sw_nresp", o_nresp, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit for the single-issue RISC-V core. It sits after the ALU, on the far side of the immediate/operand-B path.
- Takes the computed effective address, the store data (rs2_data) and funct3 from the pipeline.
- Runs one request/grant/response transaction on the data-memory port.
- Returns lane-aligned, sign- or zero-extended load data and a completion pulse; asserts stall while busy.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32 for this core. Byte-enable width is DATA_W/8.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  pipeline presents a memory op
- req_write  in  1  1=store, 0=load; driven by mem_write_en
- funct3  in  3  instruction[14:12]
- addr  in  ADDR_W  effective address (ALU result)
- wdata  in  32  store data (rs2_data)
- req_ready  out  1  unit idle, can accept an op
- stall  out  1  unit busy; pipeline holds
- resp_valid  out  1  one-cycle completion pulse
- rdata  out  32  extended load result; 0 for stores and faults
- fault  out  1  valid with resp_valid; misaligned or illegal funct3
- mem_req  out  1  memory request
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  word-aligned address, addr[1:0]=00
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  memory accepted the request this cycle
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  load data word

Behaviour:
- Reset:
  - Asynchronous; state=IDLE.
  - req_ready=1; stall, resp_valid, fault, mem_req, mem_we = 0.
  - rdata, mem_addr, mem_be, mem_wdata = 0.
  - Reset asserted mid-transaction drops mem_req immediately and discards the op. No resp_valid.
- FSM states: IDLE, REQ, WAIT, RESP. stall = (state != IDLE); req_ready = (state == IDLE).
- IDLE:
  - On req_valid, capture addr, funct3, req_write and wdata.
  - Legal, aligned op -> REQ.
  - Otherwise -> RESP with fault=1.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=00.
- REQ:
  - mem_req=1 with mem_addr, mem_we, mem_be and mem_wdata held stable until mem_gnt.
  - On mem_gnt: store -> RESP; load -> WAIT.
  - mem_rvalid is ignored in REQ.
- WAIT: mem_req=0. On mem_rvalid, register the extracted result into rdata and go to RESP. No timeout.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - rdata and fault hold their values until the next RESP.
  - A new op can be accepted the cycle after RESP.
- Byte enables:
  - SB/LB/LBU: 0001 << addr[1:0].
  - SH/LH/LHU: 0011 << addr[1:0].
  - Word ops: 1111.
  - mem_be=0000 whenever mem_req=0.
- Store data: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
- Load extraction:
  - Byte = mem_rdata[8*addr[1:0] +: 8]; halfword = mem_rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Latency:
  - Op accepted at cycle T, mem_gnt at T+1: store resp_valid at T+2.
  - Load with mem_rvalid at T+2: resp_valid at T+3.
  - Fault: resp_valid at T+1, no memory access.
- req_valid while busy is ignored. The pipeline holds its inputs because stall=1.

Decomposition:
- Shared package lsu_pkg:
  - funct3 encodings for LB, LH, LW, LBU, LHU, SB, SH, SW.
  - FSM state enum.
  - Size encoding (byte, half, word).
- One natural sub-module, lsu_align (purely combinational):
  - Generates be and lane-replicated write data from size and addr[1:0].
  - Extracts and extends the load result from mem_rdata, addr[1:0] and funct3.
  - The FSM and registers stay in lsu.

Test Plan:
1. SW addr=0x100, wdata=0xDEADBEEF, mem_gnt same cycle as REQ -> mem_addr=0x100, mem_be=1111, mem_wdata=0xDEADBEEF, mem_we=1; resp_valid 2 cycles after accept; fault=0.
2. LB addr=0x203, mem_rdata=0x80FF7F01 -> mem_be=1000; rdata=0xFFFFFF80. Repeat as LBU -> rdata=0x00000080.
3. SH addr=0x302, wdata=0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x300. Then LH addr=0x302 with mem_rdata=0xABCD0000 -> rdata=0xFFFFABCD.
4. LW addr=0x401 -> no mem_req ever; resp_valid 1 cycle after accept with fault=1, rdata=0. Also funct3=011 load -> fault=1.
5. LW with mem_gnt delayed 3 cycles and mem_rvalid delayed 2 more -> mem_req and all memory outputs stable throughout; stall=1; exactly one resp_valid; rdata=mem_rdata.
6. rst_n asserted low while in WAIT -> mem_req=0 and req_ready=1 immediately; no resp_valid after release. A following SW completes normally.
